taus_stream_checker: RTL

Self-synchronising receiver/checker for 32-bit words produced by a single xorshift/Tausworthe generator stage. It runs the same step function (`CONST`, `SHIFT_L1`, `SHIFT_L2`, `SHIFT_R`) as the producing stage and predicts each next word from the previous one. It acquires lock, then counts and flags mismatches. It sits at the consuming end of a generator link, e.g. after a FIFO or serial channel, to qualify the channel or the generator itself.

---
 rtl/taus_stream_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/taus_stream_checker.sv
// Lock-acquiring checker for a Tausworthe/xorshift word stream.
// Predicts each word from the last and counts mismatches once locked.
module taus_stream_checker #(
    parameter logic [31:0] CONST      = 32'hFFFF_FFFE,
    parameter int unsigned SHIFT_L1   = 13,
    parameter int unsigned SHIFT_L2   = 12,
    parameter int unsigned SHIFT_R    = 19,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

    function automatic logic [31:0] step_f(input logic [31:0] s);
        return (((s << SHIFT_L1) ^ s) >> SHIFT_R) ^ ((s & CONST) << SHIFT_L2);
    endfunction

    logic [31:0] pred, pred_n;
    logic [7:0]  run, run_n;
    logic [7:0]  miss, miss_n;
    logic [1:0]  state_n;
    logic [15:0] cnt_n;
    logic [31:0] src;
    logic [31:0] f_src;
    logic        match;
    logic        err;

    assign match = (in_data == pred);

    // On a locked mismatch the received word is distrusted: flywheel on pred.
    always_comb begin
        src = in_data;
        if (state == LOCKED && !match)
            src = pred;
        f_src = step_f(src);
    end

    always_comb begin
        state_n = state;
        pred_n  = pred;
        run_n   = run;
        miss_n  = miss;
        err     = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    if (in_data != 32'd0) begin
                        pred_n  = f_src;
                        run_n   = 8'd0;
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    if (match) begin
                        run_n  = run + 8'd1;
                        pred_n = f_src;
                        if (run_n == LOCK_N) begin
                            state_n = LOCKED;
                            miss_n  = 8'd0;
                        end
                    end else if (in_data == 32'd0) begin
                        run_n   = 8'd0;
                        state_n = HUNT;
                    end else begin
                        pred_n = f_src;
                        run_n  = 8'd0;
                    end
                end
                LOCKED: begin
                    pred_n = f_src;
                    if (match) begin
                        miss_n = 8'd0;
                    end else begin
                        err    = 1'b1;
                        miss_n = miss + 8'd1;
                        if (miss_n == UNLOCK_N)
                            state_n = HUNT;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_comb begin
        cnt_n = err_count;
        if (clr_cnt)
            cnt_n = {15'd0, err};
        else if (err && err_count != 16'hFFFF)
            cnt_n = err_count + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            pred      <= 32'd0;
            run       <= 8'd0;
            miss      <= 8'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 16'd0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            run       <= run_n;
            miss      <= miss_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= err;
            err_count <= cnt_n;
        end
    end

endmodule
